conv_maxpool_ternarize: RTL and testbench

- Downstream stage of the ternary convolution core.
- Consumes the raster-ordered signed 6-bit convolution stream, applies 2x2 stride-2 max-pooling, then re-quantizes each pooled value to a 2-bit ternary code for the next layer's feature-map loader.
- Holds one half-width line of partial maxima, so a whole pooled map is produced on the fly with no frame buffer.

---
 rtl/conv_maxpool_ternarize_pkg.sv | 17 +
 rtl/ternary_quantizer.sv | 26 ++
 rtl/conv_maxpool_ternarize.sv | 137 +++++++++++++
 tb/tb_conv_maxpool_ternarize.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_maxpool_ternarize_pkg.sv
// Shared constants for the ternary conv pooling stage.
// Ternary codes, FSM encodings and default sample widths.
package conv_maxpool_ternarize_pkg;

  localparam int CONV_WIDTH = 6;
  localparam int DATA_WIDTH = 2;

  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_NEG  = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/ternary_quantizer.sv
// Combinational ternary quantizer: signed v against +/-T.
// Ports: i_v value, i_thr threshold (>= 0), o_code ternary code.
module ternary_quantizer #(
  parameter int CW = conv_maxpool_ternarize_pkg::CONV_WIDTH
) (
  input  logic signed [CW-1:0] i_v,
  input  logic signed [CW-1:0] i_thr,
  output logic        [1:0]    o_code
);
  import conv_maxpool_ternarize_pkg::*;

  logic signed [CW-1:0] w_neg_thr;

  assign w_neg_thr = -i_thr;

  // Positive test first so T = 0 sends v = 0 to +1.
  always_comb begin
    o_code = TERN_ZERO;
    if (i_v >= i_thr) begin
      o_code = TERN_POS;
    end else if (i_v <= w_neg_thr) begin
      o_code = TERN_NEG;
    end
  end

endmodule

// File: rtl/conv_maxpool_ternarize.sv
// 2x2 stride-2 max-pool of a raster conv stream, then ternarize.
// Ports: clk/rst, start+fmap_dim+thr, conv_in/in_valid in;
// out_data/out_valid/out_x/out_y pooled pixels, busy, done.
module conv_maxpool_ternarize #(
  parameter int CONV_WIDTH =
    conv_maxpool_ternarize_pkg::CONV_WIDTH,
  parameter int DATA_WIDTH =
    conv_maxpool_ternarize_pkg::DATA_WIDTH,
  parameter int MAX_DIM = 26
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [4:0]                   fmap_dim,
  input  logic signed [CONV_WIDTH-1:0] thr,
  input  logic signed [CONV_WIDTH-1:0] conv_in,
  input  logic                         in_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic [3:0]                   out_x,
  output logic [3:0]                   out_y,
  output logic                         busy,
  output logic                         done
);
  import conv_maxpool_ternarize_pkg::*;

  localparam int LB_DEPTH = MAX_DIM / 2;

  logic [1:0]                  r_state;
  logic [4:0]                  r_n;
  logic [4:0]                  r_col;
  logic [4:0]                  r_row;
  logic signed [CONV_WIDTH-1:0] r_thr;
  logic signed [CONV_WIDTH-1:0] r_pair;
  logic signed [CONV_WIDTH-1:0] r_lb [LB_DEPTH];

  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic [3:0]            r_out_x;
  logic [3:0]            r_out_y;

  logic                         w_accept;
  logic                         w_col_last;
  logic                         w_row_last;
  logic signed [CONV_WIDTH-1:0] w_h;
  logic signed [CONV_WIDTH-1:0] w_lb_rd;
  logic signed [CONV_WIDTH-1:0] w_v;
  logic [1:0]                   w_code;

  assign w_accept   = (r_state == S_RUN) && in_valid;
  assign w_col_last = (r_col == r_n - 5'd1);
  assign w_row_last = (r_row == r_n - 5'd1);

  assign w_h     = (r_pair > conv_in) ? r_pair : conv_in;
  assign w_lb_rd = r_lb[r_col[4:1]];
  assign w_v     = (w_lb_rd > w_h) ? w_lb_rd : w_h;

  ternary_quantizer #(
    .CW (CONV_WIDTH)
  ) u_quant (
    .i_v    (w_v),
    .i_thr  (r_thr),
    .o_code (w_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_thr       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_pair      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_n     <= fmap_dim;
            r_thr   <= thr;
            r_col   <= '0;
            r_row   <= '0;
            r_out_x <= '0;
            r_out_y <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            // Odd N needs no masking: its last column is
            // even and its last row is even, so neither
            // ever completes a window.
            if (!r_col[0]) begin
              r_pair <= conv_in;
            end else if (r_row[0]) begin
              r_out_valid <= 1'b1;
              r_out_data  <= DATA_WIDTH'(w_code);
              r_out_x     <= r_col[4:1];
              r_out_y     <= r_row[4:1];
            end
            if (w_col_last) begin
              r_col <= '0;
              r_row <= r_row + 5'd1;
            end else begin
              r_col <= r_col + 5'd1;
            end
            if (w_col_last && w_row_last) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Even rows park horizontal maxima for the odd row below.
  always_ff @(posedge clk) begin
    if (w_accept && r_col[0] && !r_row[0]) begin
      r_lb[r_col[4:1]] <= w_h;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign busy      = (r_state == S_RUN) ||
                     (r_state == S_FLUSH);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_conv_maxpool_ternarize.sv
// Self-checking bench for conv_maxpool_ternarize.
// Behavioural pooled/ternary model with per-cycle compare.
module tb_conv_maxpool_ternarize;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        fmap_dim;
  logic signed [5:0] thr;
  logic signed [5:0] conv_in;
  logic              in_valid;
  logic [1:0]        out_data;
  logic              out_valid;
  logic [3:0]        out_x;
  logic [3:0]        out_y;
  logic              busy;
  logic              done;

  conv_maxpool_ternarize dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fmap_dim  (fmap_dim),
    .thr       (thr),
    .conv_in   (conv_in),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         x;
    int         y;
    logic [1:0] code;
    int         due;
  } exp_t;

  exp_t       q[$];
  logic [1:0] log_codes[$];
  int         mv[$];
  int         img[0:675];
  int         n_cur;
  int         t_cur;
  int         k_cur;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, expv);
    end
  endtask

  function automatic logic [1:0] tern(int v, int t);
    if (v >= t) return 2'b01;
    if (v <= -t) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int mx(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Every cycle: out_valid must match the model's schedule.
  always @(negedge clk) begin
    logic ev;
    exp_t e;
    ev = (q.size() > 0) && (q[0].due == cyc);
    checks++;
    if (out_valid !== ev) begin
      errors++;
      $display("FAIL out_valid cyc %0d: got %b expected %b",
               cyc, out_valid, ev);
    end
    if (ev) begin
      e = q.pop_front();
      if (out_valid === 1'b1) begin
        chk("out_x", int'(out_x), e.x);
        chk("out_y", int'(out_y), e.y);
        chk("out_data", int'(out_data), int'(e.code));
      end
    end
    if (out_valid === 1'b1) log_codes.push_back(out_data);
  end

  task automatic begin_map(int n, int t);
    @(posedge clk); #1;
    start    = 1'b1;
    fmap_dim = 5'(n);
    thr      = 6'(t);
    in_valid = 1'b1;
    conv_in  = 6'sd21;
    n_cur    = n;
    t_cur    = t;
    k_cur    = 0;
    log_codes.delete();
    mv.delete();
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic feed(int v, int gap);
    int r, c, m;
    exp_t e;
    in_valid = 1'b1;
    conv_in  = 6'(v);
    r = k_cur / n_cur;
    c = k_cur % n_cur;
    img[k_cur] = v;
    if (r[0] && c[0] && (r / 2 < n_cur / 2) &&
        (c / 2 < n_cur / 2)) begin
      m = mx(mx(img[(r-1)*n_cur + c-1],
                img[(r-1)*n_cur + c]),
             mx(img[r*n_cur + c-1], img[r*n_cur + c]));
      e.x = c / 2;
      e.y = r / 2;
      e.code = tern(m, t_cur);
      e.due = cyc + 1;
      q.push_back(e);
      mv.push_back(m);
    end
    k_cur++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_map(string nm);
    @(negedge clk);
    chk({nm, " flush busy"}, int'(busy), 1);
    chk({nm, " flush done"}, int'(done), 0);
    @(negedge clk);
    chk({nm, " done"}, int'(done), 1);
    chk({nm, " idle busy"}, int'(busy), 0);
    chk({nm, " pending"}, q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int d[16];
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    fmap_dim = '0; thr = '0; conv_in = '0;
    @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst out_x", int'(out_x), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    begin_map(4, 2);
    for (int k = 0; k < 16; k++) feed(k, 0);
    finish_map("m1");
    chk("m1 count", log_codes.size(), 4);
    if (mv.size() == 4) begin
      chk("m1 v0", mv[0], 5);
      chk("m1 v1", mv[1], 7);
      chk("m1 v2", mv[2], 13);
      chk("m1 v3", mv[3], 15);
    end
    foreach (log_codes[i]) chk("m1 code", int'(log_codes[i]), 1);

    for (int i = 0; i < 16; i++) d[i] = -20;
    d[10] = -1; d[11] = -2; d[14] = -3; d[15] = -4;
    begin_map(4, 3);
    for (int k = 0; k < 16; k++) feed(d[k], 0);
    finish_map("m2");
    chk("m2 count", log_codes.size(), 4);
    if (log_codes.size() == 4) begin
      chk("m2 c0", int'(log_codes[0]), 3);
      chk("m2 c1", int'(log_codes[1]), 3);
      chk("m2 c2", int'(log_codes[2]), 3);
      chk("m2 c3", int'(log_codes[3]), 0);
    end

    begin_map(5, 1);
    for (int k = 0; k < 25; k++) feed(k, 0);
    finish_map("m3");
    chk("m3 count", log_codes.size(), 4);
    if (mv.size() == 4) begin
      chk("m3 v0", mv[0], 6);
      chk("m3 v3", mv[3], 18);
    end

    begin_map(2, 0);
    for (int k = 0; k < 4; k++) feed(0, 0);
    finish_map("m4");
    chk("m4 count", log_codes.size(), 1);
    if (log_codes.size() == 1)
      chk("m4 code", int'(log_codes[0]), 1);

    begin_map(2, 1);
    for (int k = 0; k < 4; k++) feed(0, 0);
    finish_map("m5");
    chk("m5 count", log_codes.size(), 1);
    if (log_codes.size() == 1)
      chk("m5 code", int'(log_codes[0]), 0);

    begin_map(26, int'($urandom_range(0, 12)));
    for (int k = 0; k < 676; k++)
      feed(int'($urandom_range(0, 63)) - 32,
           (k == 675) ? 0 : int'($urandom_range(0, 1)));
    finish_map("m6");
    chk("m6 count", log_codes.size(), 169);

    begin_map(26, 5);
    for (int k = 0; k < 30; k++)
      feed(int'($urandom_range(0, 63)) - 32, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort valid", int'(out_valid), 0);
    chk("abort pending", q.size(), 0);

    for (int r = 0; r < 2; r++) begin
      n = 4;
      begin_map(n, int'($urandom_range(0, 8)));
      for (int k = 0; k < 16; k++)
        feed(int'($urandom_range(0, 63)) - 32,
             (k == 15) ? 0 : int'($urandom_range(0, 2)));
      finish_map("m7");
      chk("m7 count", log_codes.size(), 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
